test_sequencer: RTL and testbench

TEST_SEQUENCER -- requirements
Module: test_sequencer

---
 rtl/test_sequencer.sv | 169 ++++++++++++++++
 tb/tb_test_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_sequencer.sv
// test_sequencer: streams a program into instruction memory, runs the core,
// watches the exit syscall (a7/a0/gp) and reports pass/fail/timeout/cycles.
module test_sequencer #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 512,
  parameter int MAX_CYCLES = 100000,
  parameter int PASS_CODE  = 93
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             ldValid,
  input  logic [WIDTH-1:0] ldData,
  input  logic             ldLast,
  output logic             ldReady,
  output logic             insMemEn,
  output logic [WIDTH-1:0] insMemData,
  output logic [WIDTH-1:0] insMemAddr,
  output logic             cpuReset,
  input  logic [WIDTH-1:0] gp,
  input  logic [WIDTH-1:0] a7,
  input  logic [WIDTH-1:0] a0,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [WIDTH-1:0] testNum,
  output logic [WIDTH-1:0] cycleCount
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] CODE = WIDTH'(PASS_CODE);
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_CYCLES - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             tmo_q, tmo_d;
  logic [WIDTH-1:0] tnum_q, tnum_d;
  logic [WIDTH-1:0] cyc_q, cyc_d;
  logic             armed_q, armed_d;

  logic             accept;
  logic             hit;
  logic [WIDTH-1:0] cyc_inc;

  assign ldReady  = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD) ||
                    (state_q == S_FLUSH) ||
                    (state_q == S_RUN);
  assign cpuReset = (state_q != S_RUN);

  assign insMemEn   = en_q;
  assign insMemData = data_q;
  assign insMemAddr = addr_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = tmo_q;
  assign testNum    = tnum_q;
  assign cycleCount = cyc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    tnum_d  = tnum_q;
    cyc_d   = cyc_q;
    armed_d = armed_q;

    accept  = ldValid && ldReady;
    // armed blocks a pass code left over in a7 from the previous run
    hit     = armed_q && (a7 == CODE);
    cyc_inc = (cyc_q == ALL_ONES) ? cyc_q : cyc_q + 1'b1;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
          tnum_d  = '0;
          cyc_d   = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          en_d   = 1'b1;
          data_d = ldData;
          addr_d = WIDTH'(cnt_q);
          cnt_d  = cnt_q + 1'b1;
          if (ldLast || (cnt_q == LAST_ADDR)) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_RUN;
        armed_d = 1'b0;
      end
      S_RUN: begin
        cyc_d   = cyc_inc;
        armed_d = armed_q || (a7 != CODE);
        if (hit) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (a0 == '0);
          tmo_d   = 1'b0;
          tnum_d  = gp >> 1;
        end else if (cyc_inc == LIMIT) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      tnum_q  <= '0;
      cyc_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      tnum_q  <= tnum_d;
      cyc_q   <= cyc_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: randomized load/run scenarios checked against a
// behavioural model of the load and exit-syscall rules.
module tb_test_sequencer;

  localparam int W    = 32;
  localparam int DEP  = 512;
  localparam int MAXC = 20;
  localparam int CODE = 93;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         ldValid = 1'b0;
  logic [W-1:0] ldData = '0;
  logic         ldLast = 1'b0;
  logic         ldReady;
  logic         insMemEn;
  logic [W-1:0] insMemData;
  logic [W-1:0] insMemAddr;
  logic         cpuReset;
  logic [W-1:0] gp = '0;
  logic [W-1:0] a7 = '0;
  logic [W-1:0] a0 = '0;
  logic         busy;
  logic         done;
  logic         pass;
  logic         timeout;
  logic [W-1:0] testNum;
  logic [W-1:0] cycleCount;

  int tests = 0;
  int fails = 0;

  test_sequencer #(
    .WIDTH(W), .DEPTH(DEP),
    .MAX_CYCLES(MAXC), .PASS_CODE(CODE)
  ) dut (
    .clock(clock), .reset(reset),
    .start(start), .ldValid(ldValid),
    .ldData(ldData), .ldLast(ldLast),
    .ldReady(ldReady), .insMemEn(insMemEn),
    .insMemData(insMemData),
    .insMemAddr(insMemAddr),
    .cpuReset(cpuReset), .gp(gp),
    .a7(a7), .a0(a0), .busy(busy),
    .done(done), .pass(pass),
    .timeout(timeout), .testNum(testNum),
    .cycleCount(cycleCount)
  );

  initial forever #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset(input string where);
    reset = 1'b1;
    step();
    ldValid = 1'b0;
    ldLast  = 1'b0;
    start   = 1'b0;
    tests++;
    if ({ldReady, insMemEn, cpuReset, busy,
         done, pass, timeout} !== 7'b0010000) begin
      fails++;
      $display("FAIL reset_flags(%s): got %b want 0010000", where,
        {ldReady, insMemEn, cpuReset, busy, done, pass, timeout});
    end
    tests++;
    if (insMemData !== 0 || insMemAddr !== 0) begin
      fails++;
      $display("FAIL reset_mem(%s): got data %0h addr %0h want 0 0",
        where, insMemData, insMemAddr);
    end
    tests++;
    if (testNum !== 0 || cycleCount !== 0) begin
      fails++;
      $display("FAIL reset_cnt(%s): got tn %0h cc %0h want 0 0",
        where, testNum, cycleCount);
    end
    reset = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0 || ldReady !== 1'b0 || cpuReset !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle(%s): got busy %b rdy %b cpr %b want 0 0 1",
        where, busy, ldReady, cpuReset);
    end
  endtask

  // program stream: n words, ldLast on word last_idx (-1 = never)
  task automatic test_load(input int n, input int last_idx,
                           input int vprob, input bit fixed);
    logic [W-1:0] words[$];
    int idx;
    int exp_n;
    bit took;
    idx = 0;
    for (int i = 0; i < n; i++)
      words.push_back(fixed ? 32'h13 : $urandom);
    exp_n = (last_idx >= 0) ? last_idx + 1 : n;
    if (exp_n > DEP) exp_n = DEP;
    for (int c = 0; c < 4 * n + 50 && idx < n && ldReady === 1'b1; c++) begin
      ldValid = ($urandom_range(99) < vprob);
      ldData  = words[idx];
      ldLast  = (idx == last_idx);
      took    = ldValid && ldReady;
      step();
      tests++;
      if (insMemEn !== took) begin
        fails++;
        $display("FAIL wr_en: got %b want %b (beat %0d)",
          insMemEn, took, idx);
      end
      if (took) begin
        tests++;
        if (insMemAddr !== idx || insMemData !== words[idx]) begin
          fails++;
          $display("FAIL wr_word: got addr %0d data %0h want %0d %0h",
            insMemAddr, insMemData, idx, words[idx]);
        end
        idx++;
      end
    end
    ldValid = 1'b0;
    ldLast  = 1'b0;
    tests++;
    if (idx != exp_n) begin
      fails++;
      $display("FAIL beats_accepted: got %0d want %0d", idx, exp_n);
    end
    tests++;
    if (ldReady !== 1'b0 || cpuReset !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL flush_state: got rdy %b cpr %b busy %b want 0 1 1",
        ldReady, cpuReset, busy);
    end
  endtask

  // entered in FLUSH; a7 follows seq (0 past its end) one value per RUN cycle
  task automatic test_run(input logic [W-1:0] seq[$],
                          input logic [W-1:0] a0v,
                          input logic [W-1:0] gpv);
    int end_i;
    int got;
    bit comp;
    bit seen;
    logic [W-1:0] v;
    logic [W-1:0] exp_tn;
    end_i = MAXC - 2;
    comp  = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i <= MAXC - 2; i++) begin
      v = (i < seq.size()) ? seq[i] : '0;
      if (seen && v == CODE) begin
        end_i = i;
        comp  = 1'b1;
        break;
      end
      if (v != CODE) seen = 1'b1;
    end
    exp_tn = comp ? (gpv >> 1) : '0;
    a0 = a0v;
    gp = gpv;
    step();
    tests++;
    if (cpuReset !== 1'b0 || busy !== 1'b1 || cycleCount !== 0) begin
      fails++;
      $display("FAIL run_entry: got cpr %b busy %b cc %0d want 0 1 0",
        cpuReset, busy, cycleCount);
    end
    got = -1;
    for (int i = 0; i < MAXC + 4; i++) begin
      a7 = (i < seq.size()) ? seq[i] : '0;
      step();
      if (done === 1'b1) begin
        got = i;
        break;
      end
      tests++;
      if (cpuReset !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL run_active: got cpr %b busy %b want 0 1 (cyc %0d)",
          cpuReset, busy, i);
      end
    end
    tests++;
    if (got != end_i) begin
      fails++;
      $display("FAIL run_latency: got %0d want %0d", got, end_i);
    end
    tests++;
    if (pass !== (comp && a0v == 0) || timeout !== !comp) begin
      fails++;
      $display("FAIL run_result: got pass %b tmo %b want %b %b",
        pass, timeout, comp && a0v == 0, !comp);
    end
    tests++;
    if (testNum !== exp_tn || cycleCount !== end_i + 1) begin
      fails++;
      $display("FAIL run_counts: got tn %0d cc %0d want %0d %0d",
        testNum, cycleCount, exp_tn, end_i + 1);
    end
    tests++;
    if (cpuReset !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_state: got cpr %b busy %b want 1 0",
        cpuReset, busy);
    end
    for (int i = 0; i < 3; i++) begin
      a7 = (i == 1) ? CODE : $urandom;
      a0 = $urandom;
      gp = $urandom;
      step();
      tests++;
      if (done !== 1'b1 || pass !== (comp && a0v == 0) ||
          timeout !== !comp || testNum !== exp_tn ||
          cycleCount !== end_i + 1) begin
        fails++;
        $display("FAIL done_hold: got d%b p%b t%b tn %0d cc %0d",
          done, pass, timeout, testNum, cycleCount);
      end
    end
  endtask

  task automatic test_restart();
    pulse_start();
    tests++;
    if (done !== 0 || pass !== 0 || timeout !== 0 ||
        testNum !== 0 || cycleCount !== 0) begin
      fails++;
      $display("FAIL restart_clear: got d%b p%b t%b tn %0d cc %0d want 0s",
        done, pass, timeout, testNum, cycleCount);
    end
    tests++;
    if (ldReady !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_load: got rdy %b busy %b want 1 1",
        ldReady, busy);
    end
  endtask

  task automatic test_reset_load();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      ldValid = 1'b1;
      ldData  = $urandom;
      ldLast  = 1'b0;
      step();
    end
    ldData = $urandom;
    test_reset("load");
    pulse_start();
    test_load(5, 4, 100, 1'b0);
  endtask

  task automatic test_reset_run();
    step();
    a7 = '0;
    for (int i = 0; i < 4; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    tests++;
    if (busy !== 1'b1 || cpuReset !== 1'b0 || cycleCount !== 6) begin
      fails++;
      $display("FAIL start_in_run: got busy %b cpr %b cc %0d want 1 0 6",
        busy, cpuReset, cycleCount);
    end
    test_reset("run");
  endtask

  initial begin
    logic [W-1:0] q[$];
    int n;
    int r;
    test_reset("init");

    pulse_start();
    test_load(4, 3, 100, 1'b1);
    q.delete();
    q.push_back(0);
    q.push_back(CODE);
    test_run(q, 0, 1);

    test_restart();
    test_load(600, -1, 100, 1'b0);
    q.delete();
    q.push_back(CODE);
    q.push_back(CODE);
    q.push_back(CODE);
    q.push_back(5);
    q.push_back(CODE);
    test_run(q, 1, 7);

    test_restart();
    test_load(6, 5, 60, 1'b0);
    q.delete();
    test_run(q, 0, 9);

    test_restart();
    test_load(2, 1, 70, 1'b0);
    q.delete();
    repeat (MAXC - 2) q.push_back(0);
    q.push_back(CODE);
    test_run(q, 0, 11);

    for (int k = 0; k < 6; k++) begin
      test_restart();
      n = $urandom_range(20, 1);
      test_load(n, n - 1, $urandom_range(100, 30), 1'b0);
      q.delete();
      repeat ($urandom_range(24, 1)) begin
        r = $urandom_range(3);
        q.push_back(r < 2 ? CODE : (r == 2 ? 5 : $urandom));
      end
      test_run(q, $urandom_range(1) ? 0 : $urandom, $urandom);
    end

    test_restart();
    test_reset("done_load");
    test_reset_load();
    test_reset_run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
